exu_wb_tracker: RTL and testbench

Execute-stage in-flight tracker sitting between dispatch and the pipeline hazard controller. It records the destination register of every instruction issued to the three execute units: ALU, LSU and MDU. It drives the per-unit write-enable/index buses consumed by hazard detection, flags issue-to-busy-unit (resource) conflicts and flags writeback-port (wb) conflicts. It also arbitrates the single register-file write port among completing units.

---
 rtl/exu_wb_tracker.sv | 184 ++++++++++++++++++
 tb/tb_exu_wb_tracker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_wb_tracker.sv
// exu_wb_tracker: records the destination register of each instruction
// issued to the ALU, LSU and MDU execute units.
// - Publishes the pending writes to the hazard controller.
// - Flags resource and writeback-port conflicts.
// - Arbitrates the single register-file write port, with fixed priority
//   MDU > LSU > ALU.
//
// Dispatch handshake:
// - An instruction moves from dispatch into a slot at a rising edge where
//   i_dis_vld and o_issue_acpt are both high.
// - o_issue_acpt never depends on itself.
// - Dispatch may drop or change the instruction while o_issue_acpt is low.
module exu_wb_tracker #(
    parameter int RFIDX_W = 5,
    parameter int MUL_CYC = 3,
    parameter int DIV_CYC = 33
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_dis_vld,
    input  logic [1:0]         i_dis_unit,
    input  logic               i_dis_rdwen,
    input  logic [RFIDX_W-1:0] i_dis_rdidx,
    input  logic               i_dis_div,
    input  logic               i_lsu_done,
    output logic               o_issue_acpt,
    output logic               o_exu_rdwen0,
    output logic               o_exu_rdwen1,
    output logic               o_exu_rdwen2,
    output logic [RFIDX_W-1:0] o_exu_rdidx0,
    output logic [RFIDX_W-1:0] o_exu_rdidx1,
    output logic [RFIDX_W-1:0] o_exu_rdidx2,
    output logic               o_exu_resource_match,
    output logic               o_wb_match,
    output logic               o_wb_vld,
    output logic [1:0]         o_wb_unit,
    output logic               o_wb_rdwen,
    output logic [RFIDX_W-1:0] o_wb_rdidx
);

    // Counter reload values: the slot becomes ready LAT cycles after accept.
    localparam logic [5:0] MUL_LD = 6'(MUL_CYC - 1);
    localparam logic [5:0] DIV_LD = 6'(DIV_CYC - 1);

    // Slot state; bit 0 = ALU, bit 1 = LSU, bit 2 = MDU.
    logic [2:0]         busy_q,  busy_d;
    logic [2:0]         rdwen_q, rdwen_d;
    logic [RFIDX_W-1:0] rdidx0_q, rdidx0_d;
    logic [RFIDX_W-1:0] rdidx1_q, rdidx1_d;
    logic [RFIDX_W-1:0] rdidx2_q, rdidx2_d;
    logic               done1_q, done1_d;
    logic [5:0]         cnt_q,   cnt_d;

    logic [2:0] rdy;
    logic [2:0] grant;
    logic       res_match;
    logic       wb_match;
    logic       issue;
    logic       rd_we;

    // Readiness, priority grant, conflict flags and the accept decision.
    always_comb begin
        rdy[0] = busy_q[0];
        rdy[1] = busy_q[1] & (i_lsu_done | done1_q);
        rdy[2] = busy_q[2] & (cnt_q == 6'd0);

        grant = 3'b000;
        if (rdy[2])      grant = 3'b100;
        else if (rdy[1]) grant = 3'b010;
        else if (rdy[0]) grant = 3'b001;

        wb_match = (rdy[0] & rdy[1]) | (rdy[0] & rdy[2]) | (rdy[1] & rdy[2]);

        // A slot being granted this cycle frees up at the edge, so it is not
        // a conflict: this is what allows back-to-back reuse.
        res_match = 1'b0;
        case (i_dis_unit)
            2'd0:    res_match = busy_q[0] & ~grant[0];
            2'd1:    res_match = busy_q[1] & ~grant[1];
            2'd2:    res_match = busy_q[2] & ~grant[2];
            default: res_match = 1'b0;
        endcase
        res_match = res_match & i_dis_vld;

        issue = i_dis_vld & (i_dis_unit != 2'd3) & ~res_match & ~wb_match;
        rd_we = i_dis_rdwen & (i_dis_rdidx != '0);
    end

    // Writeback port driven from whichever slot holds the grant.
    always_comb begin
        o_wb_vld   = 1'b0;
        o_wb_unit  = 2'd0;
        o_wb_rdwen = 1'b0;
        o_wb_rdidx = '0;
        if (grant[2]) begin
            o_wb_vld   = 1'b1;
            o_wb_unit  = 2'd2;
            o_wb_rdwen = rdwen_q[2];
            o_wb_rdidx = rdidx2_q;
        end else if (grant[1]) begin
            o_wb_vld   = 1'b1;
            o_wb_unit  = 2'd1;
            o_wb_rdwen = rdwen_q[1];
            o_wb_rdidx = rdidx1_q;
        end else if (grant[0]) begin
            o_wb_vld   = 1'b1;
            o_wb_unit  = 2'd0;
            o_wb_rdwen = rdwen_q[0];
            o_wb_rdidx = rdidx0_q;
        end
    end

    // Next slot state: retire granted slots, then let an accepted issue win.
    always_comb begin
        busy_d   = busy_q & ~grant;
        rdwen_d  = rdwen_q & ~grant;
        rdidx0_d = rdidx0_q;
        rdidx1_d = rdidx1_q;
        rdidx2_d = rdidx2_q;
        done1_d  = done1_q;
        cnt_d    = cnt_q;

        // A finished LSU that loses arbitration remembers its result.
        if (grant[1])    done1_d = 1'b0;
        else if (rdy[1]) done1_d = 1'b1;

        if (busy_q[2] && cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;

        if (issue) begin
            case (i_dis_unit)
                2'd0: begin
                    busy_d[0]  = 1'b1;
                    rdwen_d[0] = rd_we;
                    rdidx0_d   = i_dis_rdidx;
                end
                2'd1: begin
                    busy_d[1]  = 1'b1;
                    rdwen_d[1] = rd_we;
                    rdidx1_d   = i_dis_rdidx;
                    done1_d    = 1'b0;
                end
                2'd2: begin
                    busy_d[2]  = 1'b1;
                    rdwen_d[2] = rd_we;
                    rdidx2_d   = i_dis_rdidx;
                    cnt_d      = i_dis_div ? DIV_LD : MUL_LD;
                end
                default: ;
            endcase
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            busy_q   <= '0;
            rdwen_q  <= '0;
            rdidx0_q <= '0;
            rdidx1_q <= '0;
            rdidx2_q <= '0;
            done1_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            rdwen_q  <= rdwen_d;
            rdidx0_q <= rdidx0_d;
            rdidx1_q <= rdidx1_d;
            rdidx2_q <= rdidx2_d;
            done1_q  <= done1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_issue_acpt         = issue;
    assign o_exu_resource_match = res_match;
    assign o_wb_match           = wb_match;
    assign o_exu_rdwen0         = busy_q[0] & rdwen_q[0];
    assign o_exu_rdwen1         = busy_q[1] & rdwen_q[1];
    assign o_exu_rdwen2         = busy_q[2] & rdwen_q[2];
    assign o_exu_rdidx0         = rdidx0_q;
    assign o_exu_rdidx1         = rdidx1_q;
    assign o_exu_rdidx2         = rdidx2_q;

endmodule

// File: tb/tb_exu_wb_tracker.sv
// Directed bench for exu_wb_tracker.
// - Inputs are driven 1 ns after each rising edge.
// - Outputs are checked on the falling edge.
// - A writeback monitor compares every granted writeback against exp_q,
//   packed as {unit, rdwen, rdidx}.
module tb_exu_wb_tracker;
  localparam int RFIDX_W = 5;
  localparam int MUL_CYC = 3;
  localparam int DIV_CYC = 33;
  localparam int EW      = 2 + 1 + RFIDX_W;

  logic               clk = 1'b0;
  logic               rstn;
  logic               dis_vld;
  logic [1:0]         dis_unit;
  logic               dis_rdwen;
  logic [RFIDX_W-1:0] dis_rdidx;
  logic               dis_div;
  logic               lsu_done;
  logic               issue_acpt;
  logic               rdwen0, rdwen1, rdwen2;
  logic [RFIDX_W-1:0] rdidx0, rdidx1, rdidx2;
  logic               res_match;
  logic               wb_match;
  logic               wb_vld;
  logic [1:0]         wb_unit;
  logic               wb_rdwen;
  logic [RFIDX_W-1:0] wb_rdidx;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] wb_exp;

  exu_wb_tracker #(.RFIDX_W(RFIDX_W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_dis_vld(dis_vld), .i_dis_unit(dis_unit), .i_dis_rdwen(dis_rdwen),
    .i_dis_rdidx(dis_rdidx), .i_dis_div(dis_div), .i_lsu_done(lsu_done),
    .o_issue_acpt(issue_acpt),
    .o_exu_rdwen0(rdwen0), .o_exu_rdwen1(rdwen1), .o_exu_rdwen2(rdwen2),
    .o_exu_rdidx0(rdidx0), .o_exu_rdidx1(rdidx1), .o_exu_rdidx2(rdidx2),
    .o_exu_resource_match(res_match), .o_wb_match(wb_match),
    .o_wb_vld(wb_vld), .o_wb_unit(wb_unit), .o_wb_rdwen(wb_rdwen),
    .o_wb_rdidx(wb_rdidx)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dis(input logic vld, input logic [1:0] unit, input logic we,
                         input logic [RFIDX_W-1:0] idx, input logic div);
    dis_vld   = vld;
    dis_unit  = unit;
    dis_rdwen = we;
    dis_rdidx = idx;
    dis_div   = div;
  endtask

  task automatic idle();
    set_dis(1'b0, 2'd0, 1'b0, '0, 1'b0);
    lsu_done = 1'b0;
  endtask

  function automatic logic [EW-1:0] wb_ent(input logic [1:0] u, input logic we,
                                           input logic [RFIDX_W-1:0] idx);
    return {u, we, idx};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_acpt"},  32'(issue_acpt), 0);
    check({tag, "_we0"},   32'(rdwen0), 0);
    check({tag, "_we1"},   32'(rdwen1), 0);
    check({tag, "_we2"},   32'(rdwen2), 0);
    check({tag, "_idx0"},  32'(rdidx0), 0);
    check({tag, "_idx1"},  32'(rdidx1), 0);
    check({tag, "_idx2"},  32'(rdidx2), 0);
    check({tag, "_res"},   32'(res_match), 0);
    check({tag, "_wbm"},   32'(wb_match), 0);
    check({tag, "_wbv"},   32'(wb_vld), 0);
    check({tag, "_wbu"},   32'(wb_unit), 0);
    check({tag, "_wbwe"},  32'(wb_rdwen), 0);
    check({tag, "_wbidx"}, 32'(wb_rdidx), 0);
  endtask

  // scoreboard: every writeback must match the next expected entry
  always @(negedge clk) begin
    if (wb_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_spurious", 32'(wb_vld), 0);
      end else begin
        wb_exp = exp_q.pop_front();
        check("wb_entry", 32'({wb_unit, wb_rdwen, wb_rdidx}), 32'(wb_exp));
      end
    end
  end

  initial begin
    // reset
    rstn = 1'b0;
    idle();
    repeat (2) next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("rst");
    next_cycle();

    // unit 3 never issues and never conflicts
    set_dis(1'b1, 2'd3, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    check("u3_acpt", 32'(issue_acpt), 0);
    check("u3_res", 32'(res_match), 0);
    next_cycle();

    // ALU issue rd=5
    set_dis(1'b1, 2'd0, 1'b1, 5'd5, 1'b0);
    exp_q.push_back(wb_ent(2'd0, 1'b1, 5'd5));
    @(negedge clk);
    check("alu_acpt", 32'(issue_acpt), 1);
    check("alu_we0_t", 32'(rdwen0), 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("alu_we0", 32'(rdwen0), 1);
    check("alu_idx0", 32'(rdidx0), 5);
    check("alu_wbv", 32'(wb_vld), 1);
    check("alu_wbu", 32'(wb_unit), 0);
    check("alu_wbidx", 32'(wb_rdidx), 5);
    next_cycle();
    @(negedge clk);
    check("alu_idle_we0", 32'(rdwen0), 0);
    check("alu_idle_wbv", 32'(wb_vld), 0);
    next_cycle();

    // ALU issue rd=0: not tracked, writeback without rdwen
    set_dis(1'b1, 2'd0, 1'b1, 5'd0, 1'b0);
    exp_q.push_back(wb_ent(2'd0, 1'b0, 5'd0));
    @(negedge clk);
    check("x0_acpt", 32'(issue_acpt), 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("x0_we0", 32'(rdwen0), 0);
    check("x0_wbv", 32'(wb_vld), 1);
    check("x0_wbwe", 32'(wb_rdwen), 0);
    next_cycle();

    // MDU divide rd=7 at T
    set_dis(1'b1, 2'd2, 1'b1, 5'd7, 1'b1);
    exp_q.push_back(wb_ent(2'd2, 1'b1, 5'd7));
    @(negedge clk);
    check("div_acpt", 32'(issue_acpt), 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("div_we2", 32'(rdwen2), 1);
    check("div_idx2", 32'(rdidx2), 7);
    repeat (3) next_cycle();
    // T+4: second MDU issue conflicts
    set_dis(1'b1, 2'd2, 1'b1, 5'd8, 1'b0);
    @(negedge clk);
    check("div_res", 32'(res_match), 1);
    check("div_res_acpt", 32'(issue_acpt), 0);
    next_cycle();
    idle();
    repeat (DIV_CYC - 6) next_cycle();
    // T+DIV_CYC-1: not yet ready
    @(negedge clk);
    check("div_early_wbv", 32'(wb_vld), 0);
    check("div_early_we2", 32'(rdwen2), 1);
    next_cycle();
    // T+DIV_CYC: writeback, re-presented MDU multiply rd=10 accepted
    set_dis(1'b1, 2'd2, 1'b1, 5'd10, 1'b0);
    exp_q.push_back(wb_ent(2'd2, 1'b1, 5'd10));
    @(negedge clk);
    check("div_wbv", 32'(wb_vld), 1);
    check("div_wbu", 32'(wb_unit), 2);
    check("div_wbidx", 32'(wb_rdidx), 7);
    check("reuse_res", 32'(res_match), 0);
    check("reuse_acpt", 32'(issue_acpt), 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("mul_we2", 32'(rdwen2), 1);
    check("mul_idx2", 32'(rdidx2), 10);
    check("mul_early_wbv", 32'(wb_vld), 0);
    repeat (MUL_CYC - 1) next_cycle();
    @(negedge clk);
    check("mul_wbv", 32'(wb_vld), 1);
    check("mul_wbidx", 32'(wb_rdidx), 10);
    next_cycle();
    @(negedge clk);
    check("mul_idle_we2", 32'(rdwen2), 0);
    next_cycle();

    // LSU rd=3 (stray lsu_done while idle is ignored), then ALU rd=4
    set_dis(1'b1, 2'd1, 1'b1, 5'd3, 1'b0);
    lsu_done = 1'b1;
    exp_q.push_back(wb_ent(2'd1, 1'b1, 5'd3));
    exp_q.push_back(wb_ent(2'd0, 1'b1, 5'd4));
    @(negedge clk);
    check("lsu_acpt", 32'(issue_acpt), 1);
    next_cycle();
    idle();
    set_dis(1'b1, 2'd0, 1'b1, 5'd4, 1'b0);
    @(negedge clk);
    check("lsu_notrdy_wbv", 32'(wb_vld), 0);
    check("lsu_we1", 32'(rdwen1), 1);
    check("alu2_acpt", 32'(issue_acpt), 1);
    next_cycle();
    // both ready; dispatch to idle MDU is held off
    set_dis(1'b1, 2'd2, 1'b1, 5'd6, 1'b0);
    lsu_done = 1'b1;
    @(negedge clk);
    check("conf_wbm", 32'(wb_match), 1);
    check("conf_wbu", 32'(wb_unit), 1);
    check("conf_wbidx", 32'(wb_rdidx), 3);
    check("conf_res", 32'(res_match), 0);
    check("conf_acpt", 32'(issue_acpt), 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("conf2_wbm", 32'(wb_match), 0);
    check("conf2_wbu", 32'(wb_unit), 0);
    check("conf2_wbidx", 32'(wb_rdidx), 4);
    next_cycle();
    @(negedge clk);
    check("conf3_wbv", 32'(wb_vld), 0);
    next_cycle();

    // multiply rd=9 at T, LSU rd=11 at T+1, LSU done at T+MUL_CYC
    set_dis(1'b1, 2'd2, 1'b1, 5'd9, 1'b0);
    exp_q.push_back(wb_ent(2'd2, 1'b1, 5'd9));
    exp_q.push_back(wb_ent(2'd1, 1'b1, 5'd11));
    @(negedge clk);
    check("m2_acpt", 32'(issue_acpt), 1);
    next_cycle();
    set_dis(1'b1, 2'd1, 1'b1, 5'd11, 1'b0);
    @(negedge clk);
    check("m2_lsu_acpt", 32'(issue_acpt), 1);
    next_cycle();
    idle();
    repeat (MUL_CYC - 2) next_cycle();
    lsu_done = 1'b1;
    @(negedge clk);
    check("m2_wbm", 32'(wb_match), 1);
    check("m2_wbu", 32'(wb_unit), 2);
    next_cycle();
    lsu_done = 1'b0;
    @(negedge clk);
    check("m2_done_wbv", 32'(wb_vld), 1);
    check("m2_done_wbu", 32'(wb_unit), 1);
    check("m2_done_idx", 32'(wb_rdidx), 11);
    next_cycle();
    @(negedge clk);
    check("m2_idle_wbv", 32'(wb_vld), 0);
    check("m2_idle_we1", 32'(rdwen1), 0);
    next_cycle();

    // reset while MDU counter is 10 and LSU busy
    set_dis(1'b1, 2'd2, 1'b1, 5'd12, 1'b1);
    @(negedge clk);
    check("rd_div_acpt", 32'(issue_acpt), 1);
    next_cycle();
    set_dis(1'b1, 2'd1, 1'b1, 5'd13, 1'b0);
    @(negedge clk);
    check("rd_lsu_acpt", 32'(issue_acpt), 1);
    next_cycle();
    idle();
    repeat (DIV_CYC - 1 - 10 - 1) next_cycle();
    @(negedge clk);
    check("rd_pre_we1", 32'(rdwen1), 1);
    check("rd_pre_we2", 32'(rdwen2), 1);
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("rd");
    next_cycle();
    lsu_done = 1'b1;
    @(negedge clk);
    check("rd_lsu_ign_wbv", 32'(wb_vld), 0);
    next_cycle();
    idle();
    repeat (40) next_cycle();
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
